// File: rtl/cla_pkg.sv
// Shared definitions for the pipelined carry-lookahead adder/subtractor:
// block-count helpers and the per-stage control bundle.
package cla_pkg;

    // Control part of a stage bundle. The data part (partial S, remaining A/B,
    // carry) depends on DATA_WIDTH and is therefore declared in the top module.
    typedef struct packed {
        logic valid;
        logic sub;
        logic sat;
    } stage_ctrl_t;

    function automatic int cla_blocks(input int data_width, input int block_size);
        return data_width / block_size;
    endfunction

    function automatic bit cla_width_ok(input int data_width, input int block_size);
        return (block_size > 32'sd0) && (data_width >= block_size) &&
               ((data_width % block_size) == 32'sd0);
    endfunction

endpackage

// File: rtl/pipelined_cla_addsub_if.sv
// Operand/result handshake bundle of pipelined_cla_addsub.
// PIPELINED_CLA_SATURATE_EN adds the SAT operand bit.
interface pipelined_cla_addsub_if #(
    parameter int DATA_WIDTH = 16
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] A;
    logic [DATA_WIDTH-1:0] B;
    logic                  Cin;
    logic                  SUB;
`ifdef PIPELINED_CLA_SATURATE_EN
    logic                  SAT;
`endif
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] S;
    logic                  CF;
    logic                  OF;
    logic                  ZF;

    modport master (
        output in_valid, A, B, Cin, SUB, out_ready,
`ifdef PIPELINED_CLA_SATURATE_EN
        output SAT,
`endif
        input  in_ready, out_valid, S, CF, OF, ZF
    );

    modport slave (
        input  in_valid, A, B, Cin, SUB, out_ready,
`ifdef PIPELINED_CLA_SATURATE_EN
        input  SAT,
`endif
        output in_ready, out_valid, S, CF, OF, ZF
    );
endinterface

// File: rtl/cla_pipe_stage.sv
// Combinational BLOCK_SIZE-bit carry-lookahead block: block sum, block
// carry-out (G + P.cin) and the carry into the block's top bit.
module cla_pipe_stage #(
    parameter int BLOCK_SIZE = 4
) (
    input  logic [BLOCK_SIZE-1:0] a,
    input  logic [BLOCK_SIZE-1:0] b,
    input  logic                  cin,
    output logic [BLOCK_SIZE-1:0] sum,
    output logic                  cout,
    output logic                  cmsb
);
    logic [BLOCK_SIZE-1:0] p;
    logic [BLOCK_SIZE-1:0] g;
    logic [BLOCK_SIZE:0]   gen;
    logic [BLOCK_SIZE:0]   prop;
    logic [BLOCK_SIZE-1:0] c;

    // gen[i]/prop[i]: group generate/propagate of bits [i-1:0], flattened lookahead
    always_comb begin
        logic term;
        p    = a ^ b;
        g    = a & b;
        gen  = {(BLOCK_SIZE+1){1'b0}};
        prop = {(BLOCK_SIZE+1){1'b0}};
        prop[0] = 1'b1;
        term = 1'b0;
        for (int i = 1; i <= BLOCK_SIZE; i++) begin
            prop[i] = 1'b1;
            for (int j = 0; j < i; j++) begin
                prop[i] = prop[i] & p[j];
                term = g[j];
                for (int m = j + 1; m < i; m++) begin
                    term = term & p[m];
                end
                gen[i] = gen[i] | term;
            end
        end
        for (int i = 0; i < BLOCK_SIZE; i++) begin
            c[i] = gen[i] | (prop[i] & cin);
        end
        sum  = p ^ c;
        cout = gen[BLOCK_SIZE] | (prop[BLOCK_SIZE] & cin);
        cmsb = c[BLOCK_SIZE-1];
    end
endmodule

// File: rtl/pipelined_cla_addsub.sv
// Pipelined adder/subtractor: one lookahead block resolved per stage, whole-pipe
// stall on backpressure. PIPELINED_CLA_SATURATE_EN enables signed saturation.
module pipelined_cla_addsub
    import cla_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int BLOCK_SIZE = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    pipelined_cla_addsub_if.slave  bus
);
    localparam int STAGES = cla_blocks(DATA_WIDTH, BLOCK_SIZE);

    if (!cla_width_ok(DATA_WIDTH, BLOCK_SIZE)) begin : g_width_check
        $error("pipelined_cla_addsub: DATA_WIDTH must be a multiple of BLOCK_SIZE");
    end

    // Operands shift right one block per stage; sums shift in from the top.
    logic [DATA_WIDTH-1:0] a_r [STAGES];
    logic [DATA_WIDTH-1:0] b_r [STAGES];
    logic [DATA_WIDTH-1:0] s_r [STAGES];
    logic                  c_r [STAGES];
    stage_ctrl_t           ctrl_r [STAGES];
    logic                  of_r;
    logic                  zf_r;

    logic [DATA_WIDTH-1:0] a_n [STAGES];
    logic [DATA_WIDTH-1:0] b_n [STAGES];
    logic [DATA_WIDTH-1:0] s_n [STAGES];
    logic                  c_n [STAGES];
    logic                  cmsb_s [STAGES];
    stage_ctrl_t           ctrl_n [STAGES];

    logic                  adv_s;
    logic                  sat_s;
    logic [DATA_WIDTH-1:0] s_fin_s;
    logic                  of_fin_s;
    logic                  zf_fin_s;

`ifdef PIPELINED_CLA_SATURATE_EN
    assign sat_s = bus.SAT;
`else
    assign sat_s = 1'b0;
`endif

    assign adv_s        = bus.out_ready | ~ctrl_r[STAGES-1].valid;
    assign bus.in_ready = adv_s;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [DATA_WIDTH-1:0] a_in;
        logic [DATA_WIDTH-1:0] b_in;
        logic [DATA_WIDTH-1:0] s_in;
        logic                  c_in;
        stage_ctrl_t           ctrl_in;
        logic [BLOCK_SIZE-1:0] blk_sum;
        logic                  blk_cout;
        logic                  blk_cmsb;

        if (k == 0) begin : g_first
            // Subtraction is A + ~B + 1, conditioned once at the pipe entry.
            assign a_in    = bus.A;
            assign b_in    = bus.SUB ? ~bus.B : bus.B;
            assign c_in    = bus.SUB ? 1'b1 : bus.Cin;
            assign s_in    = {DATA_WIDTH{1'b0}};
            assign ctrl_in = '{valid: bus.in_valid, sub: bus.SUB, sat: sat_s};
        end else begin : g_next
            assign a_in    = a_r[k-1];
            assign b_in    = b_r[k-1];
            assign c_in    = c_r[k-1];
            assign s_in    = s_r[k-1];
            assign ctrl_in = ctrl_r[k-1];
        end

        cla_pipe_stage #(.BLOCK_SIZE(BLOCK_SIZE)) u_blk (
            .a    (a_in[BLOCK_SIZE-1:0]),
            .b    (b_in[BLOCK_SIZE-1:0]),
            .cin  (c_in),
            .sum  (blk_sum),
            .cout (blk_cout),
            .cmsb (blk_cmsb)
        );

        assign a_n[k]    = a_in >> BLOCK_SIZE;
        assign b_n[k]    = b_in >> BLOCK_SIZE;
        assign s_n[k]    = (s_in >> BLOCK_SIZE) | (DATA_WIDTH'(blk_sum) << (DATA_WIDTH - BLOCK_SIZE));
        assign c_n[k]    = blk_cout;
        assign cmsb_s[k] = blk_cmsb;
        assign ctrl_n[k] = ctrl_in;
    end

    // Final-stage flags and optional clamp to the signed extreme on overflow
    always_comb begin
        of_fin_s = c_n[STAGES-1] ^ cmsb_s[STAGES-1];
        if (ctrl_n[STAGES-1].sat && of_fin_s) begin
            s_fin_s = {~s_n[STAGES-1][DATA_WIDTH-1], {(DATA_WIDTH-1){s_n[STAGES-1][DATA_WIDTH-1]}}};
        end else begin
            s_fin_s = s_n[STAGES-1];
        end
        zf_fin_s = (s_fin_s == {DATA_WIDTH{1'b0}});
    end

    // Pipeline registers: all stages advance together or hold together
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                a_r[k]    <= {DATA_WIDTH{1'b0}};
                b_r[k]    <= {DATA_WIDTH{1'b0}};
                s_r[k]    <= {DATA_WIDTH{1'b0}};
                c_r[k]    <= 1'b0;
                ctrl_r[k] <= '{valid: 1'b0, sub: 1'b0, sat: 1'b0};
            end
            of_r <= 1'b0;
            zf_r <= 1'b0;
        end else if (adv_s) begin
            for (int k = 0; k < STAGES; k++) begin
                a_r[k]    <= a_n[k];
                b_r[k]    <= b_n[k];
                s_r[k]    <= s_n[k];
                c_r[k]    <= c_n[k];
                ctrl_r[k] <= ctrl_n[k];
            end
            s_r[STAGES-1] <= s_fin_s;
            of_r          <= of_fin_s;
            zf_r          <= zf_fin_s;
        end else begin
            of_r <= of_r;
            zf_r <= zf_r;
        end
    end

    assign bus.out_valid = ctrl_r[STAGES-1].valid;
    assign bus.S         = s_r[STAGES-1];
    assign bus.CF        = c_r[STAGES-1];
    assign bus.OF        = of_r;
    assign bus.ZF        = zf_r;

endmodule

// File: tb/tb_pipelined_cla_addsub.sv
// Scoreboard bench for pipelined_cla_addsub: arithmetic reference model,
// random operands, random and directed backpressure, mid-flight reset.
module tb_pipelined_cla_addsub;
    localparam int DW     = 16;
    localparam int BS     = 4;
    localparam int STAGES = DW / BS;
`ifdef PIPELINED_CLA_SATURATE_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    typedef struct {
        logic [DW-1:0] s;
        logic          cf;
        logic          of;
        logic          zf;
        int            cyc;
        int            stl;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sat_drv = 1'b0;
    int   rmode = 0;
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   stall_total = 0;
    exp_t sb[$];

    pipelined_cla_addsub_if #(.DATA_WIDTH(DW)) bus();

    pipelined_cla_addsub #(.DATA_WIDTH(DW), .BLOCK_SIZE(BS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference: plain unsigned/signed integer arithmetic on the operands
    function automatic exp_t model(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                   input logic cin, input logic sub, input logic sat);
        exp_t   e;
        longint ua = a;
        longint ub = b;
        longint sa = $signed(a);
        longint sb_v = $signed(b);
        longint u;
        longint t;
        longint full = longint'(1) << DW;
        if (sub) begin
            u = ua - ub + full;
            t = sa - sb_v;
        end else begin
            u = ua + ub + longint'(cin);
            t = sa + sb_v + longint'(cin);
        end
        e.cf = (u >= full);
        e.s  = DW'(u % full);
        e.of = (t >= (full / 2)) || (t < -(full / 2));
        if (SAT_EN && sat && e.of) begin
            e.s = (t > 0) ? DW'((full / 2) - 1) : DW'(full / 2);
        end
        e.zf  = (e.s == '0);
        e.cyc = 0;
        e.stl = 0;
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, got, want, $time);
        end
    endtask

    // Scoreboard monitor: push on accept, pop and compare on consume
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (bus.out_valid && bus.out_ready) begin
                    if (sb.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_result: got S=%h, want no output", bus.S);
                    end else begin
                        e = sb.pop_front();
                        chk("S", 32'(bus.S), 32'(e.s));
                        chk("CF", 32'(bus.CF), 32'(e.cf));
                        chk("OF", 32'(bus.OF), 32'(e.of));
                        chk("ZF", 32'(bus.ZF), 32'(e.zf));
                        chk("latency", 32'(cyc), 32'(e.cyc + STAGES + (stall_total - e.stl)));
                    end
                end else if (bus.out_valid) begin
                    if (sb.size() != 0) chk("hold_S", 32'(bus.S), 32'(sb[0].s));
                    chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
                    stall_total++;
                end
                if (bus.in_valid && bus.in_ready) begin
                    e = model(bus.A, bus.B, bus.Cin, bus.SUB, sat_drv);
                    e.cyc = cyc;
                    e.stl = stall_total;
                    sb.push_back(e);
                end
            end
            cyc++;
        end
    end

    // Downstream ready pattern, applied a little after each rising edge
    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            case (rmode)
                0:       bus.out_ready = 1'b1;
                1:       bus.out_ready = 1'($urandom_range(0, 1));
                default: bus.out_ready = 1'b0;
            endcase
        end
    end

    // Called just after a rising edge; returns just after the accepting edge
    task automatic send(input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic cin, input logic sub, input logic sat);
        int n = 0;
        bus.A = a;
        bus.B = b;
        bus.Cin = cin;
        bus.SUB = sub;
        sat_drv = sat;
`ifdef PIPELINED_CLA_SATURATE_EN
        bus.SAT = sat;
`endif
        bus.in_valid = 1'b1;
        @(negedge clk);
        while (!bus.in_ready && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (n >= 100) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: in_ready stuck at 0, want 1 within 100 cycles");
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic send_rand();
        send(DW'($urandom), DW'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("drain_outstanding", 32'(sb.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.A = '0;
        bus.B = '0;
        bus.Cin = 1'b0;
        bus.SUB = 1'b0;
`ifdef PIPELINED_CLA_SATURATE_EN
        bus.SAT = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_S", 32'(bus.S), 32'd0);
        chk("rst_CF", 32'(bus.CF), 32'd0);
        chk("rst_OF", 32'(bus.OF), 32'd0);
        chk("rst_ZF", 32'(bus.ZF), 32'd0);
        @(posedge clk);
        #1;

        // Directed corner cases
        send(16'h1234, 16'h0FED, 1'b0, 1'b0, 1'b0);
        send(16'h8000, 16'h0001, 1'b0, 1'b1, 1'b0);
        send(16'h8000, 16'h0001, 1'b0, 1'b1, 1'b1);
        send(16'hFFFF, 16'h0000, 1'b1, 1'b0, 1'b0);
        send(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1);
        send(16'h0005, 16'h0005, 1'b1, 1'b1, 1'b0);
        send(16'h0003, 16'h0007, 1'b0, 1'b1, 1'b0);
        send(16'h8000, 16'h8000, 1'b0, 1'b0, 1'b1);
        wait_drain();

        // Back-to-back stream of random add/sub bundles
        for (int i = 0; i < 8; i++) send_rand();
        wait_drain();

        // Fill the pipe with downstream stalled, hold, then release
        rmode = 2;
        for (int i = 0; i < STAGES; i++) send_rand();
        repeat (3) begin
            @(negedge clk);
            #1;
            chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
            chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
        end
        @(posedge clk);
        #1;
        rmode = 0;
        send_rand();
        wait_drain();

        // Random backpressure with random input gaps
        rmode = 1;
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
            send_rand();
        end
        rmode = 0;
        wait_drain();

        // Reset with the pipe full: everything in flight is dropped
        for (int i = 0; i < STAGES; i++) send_rand();
        rst = 1'b1;
        sb.delete();
        #1;
        chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("midrst_S", 32'(bus.S), 32'd0);
        chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        send(16'h00FF, 16'h0F01, 1'b0, 1'b0, 1'b0);
        send_rand();
        wait_drain();
        repeat (STAGES + 2) @(posedge clk);
        #1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
